// File: rtl/counter_pacer.sv
// counter_pacer: synchronizes and debounces the run/dir/step switches and paces
// one-cycle count-enable ticks. Define COUNTER_PACER_STEP_EN to build the KEY0 step path.

module counter_pacer_deb #(
    parameter int   DEB_CYCLES = 1,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_stable_nxt
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_stb;
    logic [CW-1:0] r_cnt;
    logic          w_stb_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // The counter only runs while the synchronized value disagrees with the
    // accepted one; any agreement (a bounce back) restarts it from zero.
    always_comb begin
        w_stb_nxt = r_stb;
        w_cnt_nxt = '0;
        if (r_s2 != r_stb) begin
            if (r_cnt == CW'(DEB_CYCLES - 1))
                w_stb_nxt = r_s2;
            else
                w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1  <= RST_VAL;
            r_s2  <= RST_VAL;
            r_stb <= RST_VAL;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_stb <= w_stb_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_stable     = r_stb;
    assign o_stable_nxt = w_stb_nxt;
endmodule

module counter_pacer #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic PIN_Y2,
    input  logic SW0,
    input  logic SW17,
    input  logic SW16,
    input  logic KEY0,
    output logic tick,
    output logic dir,
    output logic running
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PW    = $clog2(DIV);
    localparam int L_RUN = 0;
    localparam int L_DIR = 1;
`ifdef COUNTER_PACER_STEP_EN
    localparam int                 NUM_IN   = 3;
    localparam int                 L_KEY    = 2;
    localparam logic [NUM_IN-1:0]  RST_VALS = 3'b100;
`else
    localparam int                 NUM_IN   = 2;
    localparam logic [NUM_IN-1:0]  RST_VALS = 2'b00;
`endif

    typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_stb;
    logic [NUM_IN-1:0] w_stb_nxt;
    logic              w_run;
    logic              w_press;
    logic              w_nxt_unused;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_presc;
    logic [PW-1:0]     w_presc_nxt;
    logic              r_tick;
    logic              w_tick_nxt;
    logic              r_dir;

`ifdef COUNTER_PACER_STEP_EN
    logic r_key_prev;

    assign w_raw = {KEY0, SW16, SW17};

    always_ff @(posedge PIN_Y2) begin
        if (SW0) r_key_prev <= 1'b1;
        else     r_key_prev <= w_stb[L_KEY];
    end

    // KEY0 is active-low: a press is the accepted value falling 1->0.
    assign w_press = r_key_prev & ~w_stb[L_KEY];
`else
    logic w_key_unused;

    assign w_raw        = {SW16, SW17};
    assign w_key_unused = KEY0;
    assign w_press      = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_in
            counter_pacer_deb #(
                .DEB_CYCLES(DEB_CYCLES),
                .RST_VAL   (RST_VALS[g])
            ) u_deb (
                .i_clk       (PIN_Y2),
                .i_rst       (SW0),
                .i_raw       (w_raw[g]),
                .o_stable    (w_stb[g]),
                .o_stable_nxt(w_stb_nxt[g])
            );
        end
    endgenerate

    // Only the dir lane needs its look-ahead value.
    assign w_nxt_unused = ^w_stb_nxt;
    assign w_run        = w_stb[L_RUN];

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_STOPPED: begin
                if (w_run)
                    w_state_nxt = ST_RUNNING;
                else if (w_press)
                    w_tick_nxt = 1'b1;
            end
            ST_RUNNING: begin
                // Leaving RUNNING clears the prescaler and swallows a due tick.
                if (!w_run)
                    w_state_nxt = ST_STOPPED;
                else if (r_presc == PW'(DIV - 1))
                    w_tick_nxt = 1'b1;
                else
                    w_presc_nxt = r_presc + 1'b1;
            end
            default: w_state_nxt = ST_STOPPED;
        endcase
    end

    always_ff @(posedge PIN_Y2) begin
        if (SW0) begin
            r_state <= ST_STOPPED;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_tick  <= w_tick_nxt;
            // Direction is frozen across a tick so the counter never sees it move mid-step.
            if (!w_tick_nxt)
                r_dir <= w_stb_nxt[L_DIR];
        end
    end

    assign tick    = r_tick;
    assign dir     = r_dir;
    assign running = (r_state == ST_RUNNING);
endmodule

// File: tb/tb_counter_pacer.sv
// tb_counter_pacer: randomized + directed bench with a behavioural model feeding
// an expected-tick queue that a separate monitor drains when the DUT ticks.

module tb_counter_pacer;
    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int DEB     = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef COUNTER_PACER_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic PIN_Y2 = 1'b0;
    logic SW0, SW17, SW16, KEY0;
    logic tick, dir, running;

    counter_pacer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DEB_CYCLES(DEB)
    ) dut (
        .PIN_Y2 (PIN_Y2),
        .SW0    (SW0),
        .SW17   (SW17),
        .SW16   (SW16),
        .KEY0   (KEY0),
        .tick   (tick),
        .dir    (dir),
        .running(running)
    );

    always #5 PIN_Y2 = ~PIN_Y2;

    typedef struct {
        int cyc;
        bit d;
    } exp_t;

    exp_t     exp_q[$];
    exp_t     mon_e;
    int       checks = 0;
    int       errors = 0;
    int       cyc    = -1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
        end
    endtask

    // A debounced value flips once the last DEB synchronized samples (raw delayed
    // by two edges) all disagree with it.
    function automatic bit settled(input bit [63:0] h, input bit stb);
        for (int k = 2; k <= DEB + 1; k++)
            if (h[k] == stb) return 1'b0;
        return 1'b1;
    endfunction

    bit [63:0] h_run, h_dir, h_key;
    bit        st_run, st_dir, st_key, key_prev;
    bit        n_run, n_dir, n_key, press, t_now;
    bit        m_running, m_dir;
    int        entry, m_presc;

    always @(posedge PIN_Y2) begin
        cyc = cyc + 1;
        if (SW0) begin
            h_run = '0; h_dir = '0; h_key = '1;
            st_run = 1'b0; st_dir = 1'b0; st_key = 1'b1; key_prev = 1'b1;
            m_running = 1'b0; m_dir = 1'b0; m_presc = 0; entry = 0;
        end else begin
            h_run = {h_run[62:0], SW17};
            h_dir = {h_dir[62:0], SW16};
            h_key = {h_key[62:0], KEY0};
            n_run = st_run ^ settled(h_run, st_run);
            n_dir = st_dir ^ settled(h_dir, st_dir);
            n_key = st_key ^ settled(h_key, st_key);
            press = STEP_EN && key_prev && !st_key;
            t_now = 1'b0;
            if (m_running) begin
                if (!st_run) m_running = 1'b0;
                else if ((cyc - entry) % DIV == 0) t_now = 1'b1;
            end else if (st_run) begin
                m_running = 1'b1;
                entry     = cyc;
            end else if (press) begin
                t_now = 1'b1;
            end
            m_presc  = m_running ? (cyc - entry) % DIV : 0;
            key_prev = st_key;
            st_run   = n_run;
            st_dir   = n_dir;
            st_key   = n_key;
            if (!t_now) m_dir = st_dir;
            if (t_now) exp_q.push_back('{cyc, m_dir});
        end
    end

    always @(negedge PIN_Y2) begin
        if (cyc >= 0) begin
            chk("running", int'(running), int'(m_running));
            chk("dir", int'(dir), int'(m_dir));
            if (tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", cyc, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tick_cycle", cyc, mon_e.cyc);
                    chk("tick_dir", int'(dir), int'(mon_e.d));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing_tick", -1, mon_e.cyc);
            end
        end
    end

    task automatic measure(input string nm, input bit use_dir, input bit target,
                           input int expv, output int nt);
        int k;
        k  = -1;
        nt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge PIN_Y2);
            nt += int'(tick);
            if ((use_dir ? dir : running) == target) begin
                k = i;
                break;
            end
        end
        chk(nm, k, expv);
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge PIN_Y2);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_tick", int'(ok), 1);
    endtask

    task automatic count_ticks(input int n, inout int cnt, inout bit saw_run);
        repeat (n) begin
            @(negedge PIN_Y2);
            cnt += int'(tick);
            saw_run |= running;
        end
    endtask

    initial begin
        int nt, cnt, first, r, sel;
        bit saw;

        SW0 = 1'b1; SW17 = 1'b0; SW16 = 1'b0; KEY0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PIN_Y2);
            SW17 = ~SW17;
            SW16 = 1'($urandom_range(0, 1));
            KEY0 = ~KEY0;
        end
        SW0 = 1'b0; SW17 = 1'b0; SW16 = 1'b0; KEY0 = 1'b1;
        repeat (2) @(negedge PIN_Y2);

        // run: 7-cycle entry latency, then 5 ticks in 50 cycles
        SW17 = 1'b1; SW16 = 1'b1;
        measure("run_latency", 1'b0, 1'b1, 7, nt);
        cnt = 0; saw = 1'b0;
        count_ticks(50, cnt, saw);
        chk("ticks_in_50", cnt, 5);

        // direction change landing on a tick edge is delayed one cycle
        wait_tick();
        repeat (4) @(negedge PIN_Y2);
        SW16 = 1'b0;
        measure("dir_latency_collide", 1'b1, 1'b0, 7, nt);
        wait_tick();
        SW16 = 1'b1;
        measure("dir_latency_free", 1'b1, 1'b1, 6, nt);

        // stop so the debounced fall lands while the prescaler sits at DIV-1
        wait_tick();
        repeat (3) @(negedge PIN_Y2);
        SW17 = 1'b0;
        measure("stop_latency", 1'b0, 1'b0, 7, nt);
        cnt = nt; saw = 1'b0;
        count_ticks(20, cnt, saw);
        chk("ticks_after_stop", cnt, 0);
        chk("presc_cleared", int'(dut.r_presc), 0);

        // bounce: 3-cycle pulses never satisfy a 4-cycle debounce
        cnt = 0; saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SW17 = ~SW17;
            count_ticks(3, cnt, saw);
        end
        count_ticks(20, cnt, saw);
        chk("bounce_running", int'(saw), 0);
        chk("bounce_ticks", cnt, 0);

        // step: a held press gives one tick (only with the step path built)
        KEY0 = 1'b0;
        cnt = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge PIN_Y2);
            if (tick && first < 0) first = i;
            cnt += int'(tick);
        end
        KEY0 = 1'b1;
        saw = 1'b0;
        count_ticks(12, cnt, saw);
        chk("step_ticks", cnt, STEP_EN ? 1 : 0);
        chk("step_latency", first, STEP_EN ? 7 : -1);

        // randomized traffic, including resets mid-count and mid-debounce
        for (int s = 0; s < 300; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                SW0 = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge PIN_Y2);
                SW0 = 1'b0;
            end else begin
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0: SW17 = ($urandom_range(0, 3) != 0);
                    1: SW16 = ~SW16;
                    2: KEY0 = ~KEY0;
                    default: begin
                        SW17 = 1'($urandom_range(0, 1));
                        SW16 = 1'($urandom_range(0, 1));
                        KEY0 = 1'($urandom_range(0, 1));
                    end
                endcase
                repeat ($urandom_range(1, 30)) @(negedge PIN_Y2);
            end
        end

        SW0 = 1'b0; SW17 = 1'b0; KEY0 = 1'b1;
        repeat (30) @(negedge PIN_Y2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
